// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and
// data load/store (D). One transaction at a time, registered memory-side
// outputs, bus-timeout watchdog.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// conflict; otherwise D has fixed priority over IF.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          timeout_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef MEM_ARB_RR_EN
    localparam logic RR_MODE = 1'b1;
`else
    localparam logic RR_MODE = 1'b0;
`endif

    logic [1:0]    state;
    logic          last_grant;   // 0 = IF, 1 = D
    logic          sel_d;        // owner of the transaction in flight
    logic [CW-1:0] wd_cnt;
    logic          grant_d;
    logic          timeout_hit;

    // Returns 1 when D should be granted. On conflict, round-robin mode
    // picks whoever was not granted last; fixed mode always picks D.
    function automatic logic pick_d(input logic if_r, input logic d_r,
                                    input logic lg);
        if (if_r && d_r)
            return RR_MODE ? ~lg : 1'b1;
        return d_r;
    endfunction

    assign grant_d     = pick_d(if_req, d_req, last_grant);
    assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == CW'(TIMEOUT - 1));

    // Arbitration FSM, latched memory request and completion handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b0;
            sel_d       <= 1'b0;
            wd_cnt      <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        sel_d      <= grant_d;
                        last_grant <= grant_d;
                        mem_req    <= 1'b1;
                        mem_we     <= grant_d && d_we;
                        mem_addr   <= grant_d ? d_addr : if_addr;
                        mem_wdata  <= grant_d ? d_wdata : '0;
                        wd_cnt     <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack || timeout_hit) begin
                        // A same-cycle ack beats the watchdog.
                        if (sel_d) begin
                            d_rdata <= mem_ack ? mem_rdata : '0;
                            d_done  <= 1'b1;
                        end else begin
                            if_rdata <= mem_ack ? mem_rdata : '0;
                            if_done  <= 1'b1;
                        end
                        if (!mem_ack)
                            timeout_err <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
